// File: rtl/jtag_seq_pkg.sv
// Shared definitions for the JTAG command sequencer: header field layout,
// FSM state encoding and error codes.
package jtag_seq_pkg;

  localparam int HDR_INST_LSB = 0;
  localparam int HDR_INST_W   = 5;
  localparam int HDR_LEN_LSB  = 5;
  localparam int HDR_LEN_W    = 8;
  localparam int HDR_DEV_LSB  = 13;
  localparam int HDR_DEV_W    = 5;
  localparam int HDR_TGT_BIT  = 18;
  localparam int HDR_VER_BIT  = 19;

  localparam int DATA_WORDS = 8;
  localparam int HDR_WORD   = 8;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_CHECK_HDR,
    S_START,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_EVAL,
    S_NEXT,
    S_FINISH,
    S_ERROR
  } seq_state_t;

  localparam logic [2:0] ERR_OK        = 3'd0;
  localparam logic [2:0] ERR_HDR       = 3'd1;
  localparam logic [2:0] ERR_START_TMO = 3'd2;
  localparam logic [2:0] ERR_DONE_TMO  = 3'd3;
  localparam logic [2:0] ERR_ABORT     = 3'd4;
  localparam logic [2:0] ERR_VERIFY    = 3'd5;

endpackage

// File: rtl/jtag_cmd_table.sv
// Command table RAM: one write port, one registered read port.
// A read and write of the same word in one cycle returns the old contents.
module jtag_cmd_table #(
  parameter int AW = 7
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [31:0]   wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [31:0]   rd_data
);

  logic [31:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/jtag_cmd_sequencer.sv
// Replays command table entries into JTAG_master, with optional verify/retry,
// timeouts, abort handling and per-sequence status reporting.
module jtag_cmd_sequencer
  import jtag_seq_pkg::*;
#(
  parameter int ENTRY_AW  = 3,
  parameter int MAX_RETRY = 3,
  parameter int START_TMO = 65535,
  parameter int DONE_TMO  = 2**22
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tbl_wr_en,
  input  logic [ENTRY_AW+3:0]   tbl_wr_addr,
  input  logic [31:0]           tbl_wr_data,
  input  logic                  run,
  input  logic                  abort,
  input  logic [ENTRY_AW:0]     num_entries,
  output logic                  jm_start_tdc,
  output logic                  jm_start_asd,
  output logic [255:0]          jm_bits,
  output logic [7:0]            jm_bit_length,
  output logic [4:0]            jm_inst,
  output logic [4:0]            jm_device_count,
  input  logic                  jm_busy,
  input  logic                  jm_equal,
  output logic                  seq_busy,
  output logic                  seq_done,
  output logic [2:0]            seq_err_code,
  output logic [ENTRY_AW-1:0]   seq_err_entry,
  output logic [7:0]            seq_retries
);

  seq_state_t          state;
  logic [ENTRY_AW-1:0] entry;
  logic [3:0]          fetch_cnt;
  logic [22:0]         tmo_cnt;
  logic [7:0]          retry_cnt;
  logic                tgt;
  logic                ver;
  logic                abort_pend;
  logic                abort_now;
  logic                rd_en;
  logic [31:0]         rd_data;
  logic [2:0]          widx;
  logic [ENTRY_AW:0]   entry_inc;
  logic                last_entry;

  assign abort_now  = abort | abort_pend;
  assign rd_en      = (state == S_FETCH) && (fetch_cnt <= 4'd8);
  assign widx       = 3'(fetch_cnt - 4'd1);
  assign entry_inc  = {1'b0, entry} + 1'b1;
  assign last_entry = (entry_inc >= num_entries) || (entry == '1);

  jtag_cmd_table #(.AW(ENTRY_AW + 4)) u_table (
    .clk     (clk),
    .wr_en   (tbl_wr_en),
    .wr_addr (tbl_wr_addr),
    .wr_data (tbl_wr_data),
    .rd_en   (rd_en),
    .rd_addr ({entry, fetch_cnt}),
    .rd_data (rd_data)
  );

  // Fetch pipelines reads one word ahead: the word read at count k lands at k+1.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      entry           <= '0;
      fetch_cnt       <= '0;
      tmo_cnt         <= '0;
      retry_cnt       <= '0;
      tgt             <= 1'b0;
      ver             <= 1'b0;
      abort_pend      <= 1'b0;
      jm_start_tdc    <= 1'b0;
      jm_start_asd    <= 1'b0;
      jm_bits         <= '0;
      jm_bit_length   <= '0;
      jm_inst         <= '0;
      jm_device_count <= '0;
      seq_busy        <= 1'b0;
      seq_done        <= 1'b0;
      seq_err_code    <= ERR_OK;
      seq_err_entry   <= '0;
      seq_retries     <= '0;
    end else begin
      jm_start_tdc <= 1'b0;
      jm_start_asd <= 1'b0;
      seq_done     <= 1'b0;
      if (abort && seq_busy) abort_pend <= 1'b1;

      case (state)
        S_IDLE: begin
          abort_pend <= 1'b0;
          if (run) begin
            seq_err_code  <= ERR_OK;
            seq_err_entry <= '0;
            seq_retries   <= '0;
            entry         <= '0;
            fetch_cnt     <= '0;
            retry_cnt     <= '0;
            seq_busy      <= 1'b1;
            if (abort) begin
              seq_err_code <= ERR_ABORT;
              state        <= S_ERROR;
            end else if (num_entries == '0) begin
              state <= S_FINISH;
            end else begin
              state <= S_FETCH;
            end
          end
        end

        S_FETCH: begin
          retry_cnt <= '0;
          if (abort_now) begin
            seq_err_code  <= ERR_ABORT;
            seq_err_entry <= entry;
            state         <= S_ERROR;
          end else begin
            if (fetch_cnt == 4'd9) begin
              jm_inst         <= rd_data[HDR_INST_LSB +: HDR_INST_W];
              jm_bit_length   <= rd_data[HDR_LEN_LSB +: HDR_LEN_W];
              jm_device_count <= rd_data[HDR_DEV_LSB +: HDR_DEV_W];
              tgt             <= rd_data[HDR_TGT_BIT];
              ver             <= rd_data[HDR_VER_BIT];
              state           <= S_CHECK_HDR;
            end else begin
              if (fetch_cnt != 4'd0) jm_bits[{widx, 5'd0} +: 32] <= rd_data;
              fetch_cnt <= fetch_cnt + 4'd1;
            end
          end
        end

        S_CHECK_HDR: begin
          if (jm_bit_length < 8'd2 || jm_device_count == 5'd0) begin
            seq_err_code  <= ERR_HDR;
            seq_err_entry <= entry;
            state         <= S_ERROR;
          end else begin
            state <= S_START;
          end
        end

        S_START: begin
          if (abort_now) begin
            seq_err_code  <= ERR_ABORT;
            seq_err_entry <= entry;
            state         <= S_ERROR;
          end else begin
            jm_start_tdc <= ~tgt;
            jm_start_asd <= tgt;
            tmo_cnt      <= '0;
            state        <= S_WAIT_BUSY;
          end
        end

        S_WAIT_BUSY: begin
          if (jm_busy) begin
            tmo_cnt <= '0;
            state   <= S_WAIT_DONE;
          end else if (tmo_cnt >= 23'(START_TMO)) begin
            seq_err_code  <= ERR_START_TMO;
            seq_err_entry <= entry;
            state         <= S_ERROR;
          end else begin
            tmo_cnt <= tmo_cnt + 23'd1;
          end
        end

        // A pending abort is only acted on once the TAP cycle has finished.
        S_WAIT_DONE: begin
          if (!jm_busy) begin
            if (abort_now) begin
              seq_err_code  <= ERR_ABORT;
              seq_err_entry <= entry;
              state         <= S_ERROR;
            end else begin
              state <= S_EVAL;
            end
          end else if (tmo_cnt >= 23'(DONE_TMO)) begin
            seq_err_code  <= ERR_DONE_TMO;
            seq_err_entry <= entry;
            state         <= S_ERROR;
          end else begin
            tmo_cnt <= tmo_cnt + 23'd1;
          end
        end

        S_EVAL: begin
          if (!ver || jm_equal) begin
            state <= S_NEXT;
          end else if (retry_cnt < 8'(MAX_RETRY)) begin
            retry_cnt <= retry_cnt + 8'd1;
            if (seq_retries != 8'hFF) seq_retries <= seq_retries + 8'd1;
            state <= S_START;
          end else begin
            seq_err_code  <= ERR_VERIFY;
            seq_err_entry <= entry;
            state         <= S_ERROR;
          end
        end

        S_NEXT: begin
          if (abort_now) begin
            seq_err_code  <= ERR_ABORT;
            seq_err_entry <= entry;
            state         <= S_ERROR;
          end else if (last_entry) begin
            state <= S_FINISH;
          end else begin
            entry     <= entry + 1'b1;
            fetch_cnt <= '0;
            state     <= S_FETCH;
          end
        end

        S_FINISH, S_ERROR: begin
          seq_done   <= 1'b1;
          seq_busy   <= 1'b0;
          abort_pend <= 1'b0;
          state      <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_cmd_sequencer.sv
// Scoreboard bench: stimulus pushes expected starts/completions, a negedge
// monitor pops and compares; a behavioural JTAG_master answers the starts.
module tb_jtag_cmd_sequencer;

  typedef struct {
    logic        asd;
    logic [4:0]  inst;
    logic [7:0]  len;
    logic [4:0]  dev;
    logic [31:0] w0;
    logic [31:0] w1;
  } exp_start_t;

  typedef struct {
    logic [2:0] code;
    logic [2:0] entry;
    logic [7:0] retries;
  } exp_done_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         tbl_wr_en = 1'b0;
  logic [6:0]   tbl_wr_addr = '0;
  logic [31:0]  tbl_wr_data = '0;
  logic         run = 1'b0;
  logic         abort = 1'b0;
  logic [3:0]   num_entries = '0;
  logic         jm_start_tdc, jm_start_asd;
  logic [255:0] jm_bits;
  logic [7:0]   jm_bit_length;
  logic [4:0]   jm_inst, jm_device_count;
  logic         jm_busy = 1'b0;
  logic         jm_equal = 1'b0;
  logic         seq_busy, seq_done;
  logic [2:0]   seq_err_code;
  logic [2:0]   seq_err_entry;
  logic [7:0]   seq_retries;

  exp_start_t exp_start_q[$];
  exp_done_t  exp_done_q[$];
  logic       eq_q[$];
  logic [31:0] hdr_tb [8];
  logic [31:0] d0_tb  [8];

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int start_idx = 0;
  int zchk_req = 0, zchk_seen = 0;
  int qchk_req = 0, qchk_seen = 0;
  int tmo_req = 0, tmo_seen = 0;
  string qchk_name = "";
  string tmo_name = "";
  logic respond = 1'b1;

  jtag_cmd_sequencer #(
    .ENTRY_AW(3), .MAX_RETRY(3), .START_TMO(100), .DONE_TMO(1000)
  ) dut (
    .clk(clk), .rst(rst),
    .tbl_wr_en(tbl_wr_en), .tbl_wr_addr(tbl_wr_addr), .tbl_wr_data(tbl_wr_data),
    .run(run), .abort(abort), .num_entries(num_entries),
    .jm_start_tdc(jm_start_tdc), .jm_start_asd(jm_start_asd),
    .jm_bits(jm_bits), .jm_bit_length(jm_bit_length), .jm_inst(jm_inst),
    .jm_device_count(jm_device_count), .jm_busy(jm_busy), .jm_equal(jm_equal),
    .seq_busy(seq_busy), .seq_done(seq_done), .seq_err_code(seq_err_code),
    .seq_err_entry(seq_err_entry), .seq_retries(seq_retries)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] hdr(input logic [4:0] inst, input logic [7:0] len,
                                      input logic [4:0] dev, input logic asd, input logic ver);
    return {12'h000, ver, asd, dev, len, inst};
  endfunction

  function automatic logic [31:0] pat(input logic [2:0] e, input logic [3:0] w);
    return {5'h14, e, 4'h0, w, 16'h3C3C};
  endfunction

  // JTAG_master stand-in: busy rises 3 cycles after a start, lasts 16 cycles.
  int m_phase = 0;
  int m_cnt = 0;
  always @(posedge clk) begin
    if (rst) begin
      m_phase <= 0;
      jm_busy <= 1'b0;
    end else if (m_phase == 0) begin
      if ((jm_start_tdc || jm_start_asd) && respond) begin
        m_phase <= 1;
        m_cnt   <= 2;
      end
    end else if (m_phase == 1) begin
      if (m_cnt == 0) begin
        jm_busy <= 1'b1;
        if (eq_q.size() > 0) jm_equal <= eq_q.pop_front();
        else jm_equal <= 1'b1;
        m_phase <= 2;
        m_cnt   <= 15;
      end else m_cnt <= m_cnt - 1;
    end else begin
      if (m_cnt == 0) begin
        jm_busy <= 1'b0;
        m_phase <= 0;
      end else m_cnt <= m_cnt - 1;
    end
  end

  // Monitor: the only process that steps total/bad.
  always @(negedge clk) begin
    exp_start_t es;
    exp_done_t  ed;
    if (!rst && (jm_start_tdc || jm_start_asd)) begin
      total++;
      start_idx++;
      if (exp_start_q.size() == 0) begin
        bad++;
        $display("[TB] FAIL start_%0d got tdc=%0b asd=%0b inst=%h required no start",
                 start_idx, jm_start_tdc, jm_start_asd, jm_inst);
      end else begin
        es = exp_start_q.pop_front();
        if (jm_start_tdc == jm_start_asd || jm_start_asd != es.asd || jm_inst != es.inst ||
            jm_bit_length != es.len || jm_device_count != es.dev ||
            jm_bits[31:0] != es.w0 || jm_bits[63:32] != es.w1) begin
          bad++;
          $display("[TB] FAIL start_%0d got tdc=%0b asd=%0b inst=%h len=%0d dev=%0d w0=%h w1=%h required asd=%0b inst=%h len=%0d dev=%0d w0=%h w1=%h",
                   start_idx, jm_start_tdc, jm_start_asd, jm_inst, jm_bit_length, jm_device_count,
                   jm_bits[31:0], jm_bits[63:32], es.asd, es.inst, es.len, es.dev, es.w0, es.w1);
        end
      end
    end
    if (!rst && seq_done) begin
      total++;
      done_cnt++;
      if (exp_done_q.size() == 0) begin
        bad++;
        $display("[TB] FAIL done_%0d got code=%0d required no seq_done", done_cnt, seq_err_code);
      end else begin
        ed = exp_done_q.pop_front();
        if (seq_err_code != ed.code || seq_err_entry != ed.entry ||
            seq_retries != ed.retries || seq_busy || jm_busy) begin
          bad++;
          $display("[TB] FAIL done_%0d got code=%0d entry=%0d retries=%0d busy=%0b jm_busy=%0b required code=%0d entry=%0d retries=%0d busy=0 jm_busy=0",
                   done_cnt, seq_err_code, seq_err_entry, seq_retries, seq_busy, jm_busy,
                   ed.code, ed.entry, ed.retries);
        end
      end
    end
    if (zchk_req != zchk_seen) begin
      zchk_seen = zchk_req;
      total++;
      if (jm_start_tdc || jm_start_asd || jm_bits != '0 || jm_bit_length != '0 || jm_inst != '0 ||
          jm_device_count != '0 || seq_busy || seq_done || seq_err_code != '0 ||
          seq_err_entry != '0 || seq_retries != '0) begin
        bad++;
        $display("[TB] FAIL reset_zero_%0d got busy=%0b done=%0b code=%0d inst=%h len=%0d bits0=%h required all 0",
                 zchk_req, seq_busy, seq_done, seq_err_code, jm_inst, jm_bit_length, jm_bits[31:0]);
      end
    end
    if (qchk_req != qchk_seen) begin
      qchk_seen = qchk_req;
      total++;
      if (exp_start_q.size() != 0 || exp_done_q.size() != 0) begin
        bad++;
        $display("[TB] FAIL %s outstanding starts=%0d dones=%0d required 0 and 0",
                 qchk_name, exp_start_q.size(), exp_done_q.size());
      end
      exp_start_q.delete();
      exp_done_q.delete();
    end
    if (tmo_req != tmo_seen) begin
      tmo_seen = tmo_req;
      total++;
      bad++;
      $display("[TB] FAIL %s wait expired got no event required event", tmo_name);
    end
  end

  task automatic write_word(input logic [2:0] e, input logic [3:0] w, input logic [31:0] d);
    @(negedge clk);
    tbl_wr_en   = 1'b1;
    tbl_wr_addr = {e, w};
    tbl_wr_data = d;
    @(negedge clk);
    tbl_wr_en   = 1'b0;
  endtask

  task automatic load_entry(input logic [2:0] e, input logic [31:0] h, input logic [31:0] d0);
    for (int w = 0; w < 8; w++) write_word(e, 4'(w), (w == 0) ? d0 : pat(e, 4'(w)));
    write_word(e, 4'd8, h);
    hdr_tb[e] = h;
    d0_tb[e]  = d0;
  endtask

  task automatic push_start(input int e);
    exp_start_t es;
    es.inst = hdr_tb[e][4:0];
    es.len  = hdr_tb[e][12:5];
    es.dev  = hdr_tb[e][17:13];
    es.asd  = hdr_tb[e][18];
    es.w0   = d0_tb[e];
    es.w1   = pat(3'(e), 4'd1);
    exp_start_q.push_back(es);
  endtask

  task automatic push_done(input logic [2:0] code, input logic [2:0] entry, input logic [7:0] retries);
    exp_done_t ed;
    ed.code = code;
    ed.entry = entry;
    ed.retries = retries;
    exp_done_q.push_back(ed);
  endtask

  task automatic pulse(input logic with_abort);
    @(negedge clk);
    run = 1'b1;
    abort = with_abort;
    @(negedge clk);
    run = 1'b0;
    abort = 1'b0;
  endtask

  task automatic wait_done(input int snap, input int budget, input string name);
    for (int i = 0; i < budget && done_cnt == snap; i++) @(negedge clk);
    if (done_cnt == snap) begin
      tmo_name = name;
      tmo_req++;
    end
  endtask

  task automatic wait_busy(input int budget, input string name);
    for (int i = 0; i < budget && !jm_busy; i++) @(negedge clk);
    if (!jm_busy) begin
      tmo_name = name;
      tmo_req++;
    end
  endtask

  task automatic apply_stimulus(input logic [3:0] n, input string name);
    int snap;
    snap = done_cnt;
    num_entries = n;
    pulse(1'b0);
    wait_done(snap, 2000, name);
  endtask

  task automatic check_output(input string name);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    qchk_name = name;
    qchk_req++;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic load_three();
    load_entry(3'd0, hdr(5'h11, 8'd32, 5'd1, 1'b0, 1'b0), 32'hDEADBEEF);
    load_entry(3'd1, hdr(5'h0A, 8'd8,  5'd2, 1'b1, 1'b0), 32'h12345678);
    load_entry(3'd2, hdr(5'h05, 8'd16, 5'd3, 1'b0, 1'b0), 32'hCAFEF00D);
  endtask

  initial begin
    int snap;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    zchk_req++;
    @(negedge clk);

    // Single TDC entry.
    load_entry(3'd0, hdr(5'h11, 8'd32, 5'd1, 1'b0, 1'b0), 32'hDEADBEEF);
    push_start(0);
    push_done(3'd0, 3'd0, 8'd0);
    apply_stimulus(4'd1, "one_entry");
    check_output("one_entry_queues");

    // TDC, ASD, TDC with a stray run mid-sequence that must be ignored.
    load_three();
    push_start(0); push_start(1); push_start(2);
    push_done(3'd0, 3'd0, 8'd0);
    snap = done_cnt;
    num_entries = 4'd3;
    pulse(1'b0);
    repeat (40) @(negedge clk);
    pulse(1'b0);
    wait_done(snap, 2000, "three_entries");
    check_output("three_entries_queues");

    // Reset in the middle of a command clears every output.
    push_start(0);
    num_entries = 4'd3;
    pulse(1'b0);
    wait_busy(200, "rst_mid_busy");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    zchk_req++;
    @(negedge clk);
    rst = 1'b0;
    check_output("rst_mid_queues");

    // Abort while the first command is in flight.
    push_start(0);
    push_done(3'd4, 3'd0, 8'd0);
    snap = done_cnt;
    num_entries = 4'd3;
    pulse(1'b0);
    wait_busy(200, "abort_busy");
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_done(snap, 2000, "abort_wait_done");
    check_output("abort_queues");

    // Verify: two mismatches, then a pass.
    load_entry(3'd0, hdr(5'h11, 8'd32, 5'd1, 1'b0, 1'b1), 32'hA5A5A5A5);
    eq_q = '{1'b0, 1'b0, 1'b1};
    push_start(0); push_start(0); push_start(0);
    push_done(3'd0, 3'd0, 8'd2);
    apply_stimulus(4'd1, "verify_retry");
    check_output("verify_retry_queues");

    // Verify: permanent mismatch exhausts the retries.
    eq_q = '{1'b0, 1'b0, 1'b0, 1'b0};
    push_start(0); push_start(0); push_start(0); push_start(0);
    push_done(3'd5, 3'd0, 8'd3);
    apply_stimulus(4'd1, "verify_fail");
    check_output("verify_fail_queues");
    eq_q.delete();

    // Bad header (len=1) in entry 1.
    load_entry(3'd0, hdr(5'h11, 8'd32, 5'd1, 1'b0, 1'b0), 32'hDEADBEEF);
    load_entry(3'd1, hdr(5'h01, 8'd1, 5'd1, 1'b0, 1'b0), 32'h0BADC0DE);
    push_start(0);
    push_done(3'd1, 3'd1, 8'd0);
    apply_stimulus(4'd2, "bad_header");
    check_output("bad_header_queues");

    // Master never goes busy.
    respond = 1'b0;
    push_start(0);
    push_done(3'd2, 3'd0, 8'd0);
    apply_stimulus(4'd1, "start_timeout");
    check_output("start_timeout_queues");
    respond = 1'b1;

    // Zero entries: immediate completion, previous error cleared.
    push_done(3'd0, 3'd0, 8'd0);
    apply_stimulus(4'd0, "zero_entries");
    check_output("zero_entries_queues");

    // run and abort together.
    push_done(3'd4, 3'd0, 8'd0);
    snap = done_cnt;
    num_entries = 4'd3;
    pulse(1'b1);
    wait_done(snap, 200, "run_abort");
    check_output("run_abort_queues");

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
